// File: rtl/disp_pkg.sv
// ============================================================================
// disp_pkg : segment types, glyph constants and BCD-to-7-segment decode table
// Revision : 1.0
// ============================================================================
`default_nettype none

package disp_pkg;

   typedef logic [6:0] t_seg;

   // Segment order is {g,f,e,d,c,b,a}, active-low
   localparam t_seg SEG_BLANK = 7'h7F;
   localparam t_seg SEG_MINUS = 7'b0111111;

   function automatic t_seg bcd_to_seg(input logic [3:0] bcd);
      t_seg seg;
      case (bcd)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_MINUS;
      endcase
      return seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_seg_decode.sv
// ============================================================================
// bcd_seg_decode : combinational BCD digit to active-low 7-segment pattern
// Revision       : 1.0
// ============================================================================
`default_nettype none

module bcd_seg_decode
   import disp_pkg::*;
(
   input  logic [3:0] i_bcd,
   output t_seg       o_seg
);

   assign o_seg = bcd_to_seg(i_bcd);

endmodule

`default_nettype wire

// File: rtl/bcd_scan_display.sv
// ============================================================================
// bcd_scan_display : latches a 4-digit BCD word and scans it onto a
//                    common-anode 7-segment display with guard and blanking
// Revision         : 1.0
// ============================================================================
`default_nettype none

module bcd_scan_display
   import disp_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int GUARD_CYCLES = 2
)(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [3:0] i_bcd [3:0],
   input  logic [3:0] i_dp,
   input  logic       i_lz_blank,
   output logic [3:0] o_an,
   output logic [6:0] o_seg,
   output logic       o_dp
);

   localparam int TICK_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DIGIT_CYCLES - 1);
   localparam logic [TICK_W-1:0] GUARD_LIM  = TICK_W'(GUARD_CYCLES);

   logic [TICK_W-1:0] tick_q,  tick_d;
   logic [1:0]        digit_q, digit_d;
   logic [3:0]        shadow_q [3:0];
   logic [3:0]        shadow_d [3:0];
   logic [3:0]        shadow_dp_q, shadow_dp_d;
   logic [3:0]        an_q,  an_d;
   t_seg              seg_q, seg_d;
   logic              dp_q,  dp_d;

   logic [3:0]        w_cur_bcd;
   t_seg              w_dec_seg;
   logic [3:0]        w_blank;
   logic              w_zero_run;
   logic              w_guard;

   // Shadow register: captured on the load strobe, held otherwise
   always_comb begin
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      if (i_load) begin
         shadow_d    = i_bcd;
         shadow_dp_d = i_dp;
      end
   end

   // Free-running slot counter; the load path never touches the scan
   always_comb begin
      tick_d  = tick_q + 1'b1;
      digit_d = digit_q;
      if (tick_q == TICK_LAST) begin
         tick_d  = '0;
         digit_d = digit_q + 2'd1;
      end
   end

   // A digit is blanked only while every digit from it upwards is a bare zero
   always_comb begin
      w_blank    = 4'b0000;
      w_zero_run = i_lz_blank;
      for (int k = 3; k >= 1; k--) begin
         w_zero_run = w_zero_run && (shadow_q[k] == 4'd0) && !shadow_dp_q[k];
         w_blank[k] = w_zero_run;
      end
   end

   assign w_cur_bcd = shadow_q[digit_q];
   assign w_guard   = (tick_q < GUARD_LIM);

   bcd_seg_decode u_seg_decode (
      .i_bcd (w_cur_bcd),
      .o_seg (w_dec_seg)
   );

   always_comb begin
      an_d  = 4'b1111;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (!w_guard && !w_blank[digit_q]) begin
         an_d  = ~(4'b0001 << digit_q);
         seg_d = w_dec_seg;
         dp_d  = ~shadow_dp_q[digit_q];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tick_q      <= '0;
         digit_q     <= 2'd0;
         shadow_dp_q <= 4'b0000;
         for (int k = 0; k < 4; k++) begin
            shadow_q[k] <= 4'd0;
         end
         an_q        <= 4'b1111;
         seg_q       <= SEG_BLANK;
         dp_q        <= 1'b1;
      end else begin
         tick_q      <= tick_d;
         digit_q     <= digit_d;
         shadow_dp_q <= shadow_dp_d;
         for (int k = 0; k < 4; k++) begin
            shadow_q[k] <= shadow_d[k];
         end
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   assign o_an  = an_q;
   assign o_seg = seg_q;
   assign o_dp  = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
// ============================================================================
// tb_bcd_scan_display : directed and random checks against a slot-arithmetic
//                       reference model of the scanned display
// ============================================================================
`default_nettype none

module tb_bcd_scan_display;

   localparam int D = 8;
   localparam int G = 2;
   localparam logic [11:0] OFF = {4'b1111, 7'h7F, 1'b1};

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_load;
   logic [3:0] i_bcd [3:0];
   logic [3:0] i_dp;
   logic       i_lz_blank;
   logic [3:0] o_an;
   logic [6:0] o_seg;
   logic       o_dp;

   int n_assert = 0;
   int n_fail   = 0;
   int n        = 0;      // active edges since reset release
   logic [3:0] msh [4];   // model of the latched digits
   logic [3:0] mdp;

   bcd_scan_display #(
      .DIGIT_CYCLES (D),
      .GUARD_CYCLES (G)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (i_load),
      .i_bcd      (i_bcd),
      .i_dp       (i_dp),
      .i_lz_blank (i_lz_blank),
      .o_an       (o_an),
      .o_seg      (o_seg),
      .o_dp       (o_dp)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // What the display should show for the state reached after k edges
   function automatic logic [11:0] model(input int k, input logic lz);
      int tick, slot;
      logic blanked;
      logic [3:0] an;
      tick = k % D;
      slot = (k / D) % 4;
      if (tick < G) return OFF;
      blanked = 1'b0;
      if (lz && slot > 0) begin
         blanked = 1'b1;
         for (int j = slot; j < 4; j++)
            if (msh[j] != 4'd0 || mdp[j]) blanked = 1'b0;
      end
      if (blanked) return OFF;
      an = 4'b1111;
      an[slot] = 1'b0;
      return {an, glyph(msh[slot]), ~mdp[slot]};
   endfunction

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                tag, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
      end
   endtask

   task automatic cycle();
      logic [11:0] e;
      e = model(n, i_lz_blank);
      @(posedge i_clk);
      if (i_load) begin
         for (int k = 0; k < 4; k++) msh[k] = i_bcd[k];
         mdp = i_dp;
      end
      n++;
      #1;
      check($sformatf("out@%0d", n), {o_an, o_seg, o_dp}, e);
   endtask

   task automatic run(input int cycles);
      for (int c = 0; c < cycles; c++) cycle();
   endtask

   task automatic load(input logic [3:0] d3, input logic [3:0] d2,
                       input logic [3:0] d1, input logic [3:0] d0, input logic [3:0] dp);
      i_bcd[3] = d3; i_bcd[2] = d2; i_bcd[1] = d1; i_bcd[0] = d0;
      i_dp   = dp;
      i_load = 1'b1;
      cycle();
      i_load = 1'b0;
   endtask

   task automatic model_reset();
      n = 0;
      for (int k = 0; k < 4; k++) msh[k] = 4'd0;
      mdp = 4'b0000;
   endtask

   initial begin
      i_rst = 1'b1; i_load = 1'b0; i_dp = 4'b0000; i_lz_blank = 1'b0;
      for (int k = 0; k < 4; k++) i_bcd[k] = 4'd0;
      model_reset();
      #22;
      check("reset_values", {o_an, o_seg, o_dp}, OFF);
      @(posedge i_clk); #1;
      i_rst = 1'b0;

      // First slot: guard for two cycles, then digit 0 shows "0"
      run(2);
      check("first_guard", {o_an, o_seg, o_dp}, OFF);
      run(1);
      check("first_on", {o_an, o_seg, o_dp}, {4'b1110, 7'b1000000, 1'b1});
      run(8);
      check("digit1_on", {o_an, o_seg, o_dp}, {4'b1101, 7'b1000000, 1'b1});
      run(5);

      load(4'd1, 4'd2, 4'd3, 4'd4, 4'b0100);
      run(40);

      i_lz_blank = 1'b1;
      load(4'd0, 4'd0, 4'd4, 4'd7, 4'b0000);
      run(32);
      i_lz_blank = 1'b0;
      run(32);

      i_lz_blank = 1'b1;
      load(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
      run(32);
      load(4'd0, 4'd12, 4'd0, 4'd5, 4'b0000);
      run(32);
      load(4'd0, 4'd0, 4'd0, 4'd0, 4'b0010);
      run(32);

      // Load on a slot's last cycle
      for (int g = 0; g < 64 && (n % D) != D - 1; g++) cycle();
      load(4'd9, 4'd8, 4'd6, 4'd5, 4'b1001);
      run(16);

      // Asynchronous reset in the middle of digit 2's ON phase
      i_lz_blank = 1'b0;
      for (int g = 0; g < 64 && (n % (4 * D)) != 2 * D + 4; g++) cycle();
      check("pre_rst_digit2", {o_an[2], o_dp}, {1'b0, ~mdp[2]});
      #2;
      i_rst = 1'b1;
      #1;
      check("async_rst", {o_an, o_seg, o_dp}, OFF);
      @(posedge i_clk); #1;
      check("rst_hold", {o_an, o_seg, o_dp}, OFF);
      model_reset();
      i_rst = 1'b0;
      run(3);
      check("restart_digit0", {o_an, o_seg, o_dp}, {4'b1110, 7'b1000000, 1'b1});
      run(29);

      // Random loads and blanking changes
      for (int r = 0; r < 600; r++) begin
         if ($urandom_range(7) == 0) begin
            for (int k = 0; k < 4; k++)
               i_bcd[k] = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'd0;
            i_dp   = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'b0000;
            i_load = 1'b1;
         end
         if ($urandom_range(31) == 0) i_lz_blank = ~i_lz_blank;
         cycle();
         i_load = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the low-frequency counter's 4-digit BCD result.
- Latches a 4-digit BCD word on a load strobe and drives a time-multiplexed, common-anode 7-segment display.
- Display features: leading-zero blanking, per-digit decimal point, a minus-sign glyph for invalid codes, and a per-slot anode guard interval to suppress ghosting.
- All display outputs are registered.

Parameters:
- DIGIT_CYCLES, 50000, i_clk cycles per digit slot (0.5 ms at 100 MHz); legal range 4..2^20.
- GUARD_CYCLES, 2, cycles at the start of each slot with all anodes off; must be < DIGIT_CYCLES.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_load  in  1  single-cycle strobe; capture i_bcd and i_dp
- i_bcd  in  4x4 (logic [3:0] i_bcd [3:0])  BCD digits; index 3 = most significant
- i_dp  in  4  decimal point enables per digit, active-high
- i_lz_blank  in  1  leading-zero blanking enable (live, not latched)
- o_an  out  4  digit anodes, active-low; o_an[k] drives digit k
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- o_dp  out  1  decimal point, active-low

Behaviour:
- Reset and clock: i_rst is asynchronous, active-high; clock is i_clk.
- Values in reset: o_an=4'b1111, o_seg=7'h7F, o_dp=1, shadow digits=0, shadow dp=0, slot counter=0, digit index=0.
- Shadow register:
  - Captures i_bcd and i_dp on the rising edge where i_load=1.
  - Holds otherwise.
  - i_load held high recaptures every cycle.
- Scan counter:
  - r_tick counts 0..DIGIT_CYCLES-1.
  - On r_tick=DIGIT_CYCLES-1, r_tick wraps to 0 and r_digit increments, wrapping 3->0.
  - Scan order: 0,1,2,3,0,...
  - Free-running from reset release; i_load never resets the scan.
- Slot phases, selected combinationally from r_tick:
  - GUARD phase while r_tick < GUARD_CYCLES.
  - ON phase otherwise.
- Output register:
  - Next-cycle outputs are computed from the current r_tick, r_digit, shadow, and i_lz_blank.
  - Outputs therefore lag the counter by exactly 1 cycle.
  - GUARD phase: o_an=1111, o_seg=7F, o_dp=1.
  - ON phase, digit not blanked: o_an has a single 0 at bit r_digit; o_seg=decode(shadow[r_digit]); o_dp=~shadow_dp[r_digit].
  - ON phase, digit blanked: o_an=1111, o_seg=7F, o_dp=1.
- Leading-zero blanking:
  - Applies only when i_lz_blank=1.
  - Digit k (k=3..1) is blanked iff shadow[k..3] are all 0 and shadow_dp[k..3] are all 0.
  - Digit 0 is never blanked, so the value 0000 displays "0".
- Decode table (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = 0111111 (minus sign)
- Load/scan interaction:
  - A load that coincides with a slot's last cycle takes effect from the next slot.
  - Mid-slot, a new value appears 2 cycles after the i_load edge (shadow, then output register).
  - No tearing within a cycle.
- Reset mid-scan: all outputs are forced off immediately (asynchronous); the scan restarts at digit 0 / tick 0.
- Full refresh period = 4*DIGIT_CYCLES cycles.

Decomposition:
- Package disp_pkg holds:
  - SEG_BLANK=7'h7F and SEG_MINUS=7'b0111111 constants
  - t_seg typedef (logic [6:0])
  - the decode table as a function bcd_to_seg(logic [3:0]) returning t_seg
- One natural sub-module, bcd_seg_decode: purely combinational wrapper around the function, instantiated once on the muxed digit.
- Scan counter, blanking, and output registers stay in the top module.

Test Plan (DIGIT_CYCLES=8, GUARD_CYCLES=2):
- Reset release, no load, i_lz_blank=0 -> first slot: o_an=1111 for cycles 1..2, then 1110 with o_seg=1000000; digit 1 slot begins at cycle 9 with anode 1101 from cycle 11.
- Load digits {3,2,1,0}={1,2,3,4}, i_dp=0100, i_lz_blank=0 -> digit-2 slot shows o_an=1011, o_seg=0100100, o_dp=0; other slots show o_dp=1.
- Load {0,0,4,7}, i_lz_blank=1, i_dp=0 -> digits 3 and 2 keep o_an=1111 through their ON phase; digit 1 shows 0011001 and digit 0 shows 1111000. With i_lz_blank=0 the same load shows 1000000 on digits 3 and 2.
- Load {0,0,0,0}, i_lz_blank=1 -> only digit 0 lights, showing 1000000; then load {0,12,0,5} -> digit 2 shows 0111111 and digit 1 shows 1000000 (not blanked, since a nonzero digit sits above it).
- Load {0,0,0,0}, i_dp=0010, i_lz_blank=1 -> digits 3 and 2 blanked; digit 1 shows 1000000 with o_dp=0.
- Assert i_rst mid-ON-phase of digit 2 -> o_an=1111 in the same cycle (asynchronous); after release the scan restarts at digit 0 and the shadow reads 0.
